// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns pipeline byte/half/word requests into
// word-aligned data-cache accesses and returns extended load results.
module lsu_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             cache_req,
   output logic             cache_we,
   output logic [WIDTH-1:0] cache_addr,
   output logic [3:0]       cache_wstrb,
   output logic [WIDTH-1:0] cache_wdata,
   input  logic             cache_ack,
   input  logic [WIDTH-1:0] cache_rdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic             stall
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t           state_r;
   logic             cache_req_r;
   logic             cache_we_r;
   logic [WIDTH-1:0] cache_addr_r;
   logic [3:0]       cache_wstrb_r;
   logic [WIDTH-1:0] cache_wdata_r;
   logic [1:0]       size_r;
   logic             unsigned_r;
   logic [1:0]       lane_r;
   logic             resp_valid_r;
   logic [WIDTH-1:0] resp_rdata_r;
   logic             resp_err_r;

   function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = lo[0];
         2'b10:   bad = (lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] store_strb(input logic we, input logic [1:0] size,
                                             input logic [1:0] lo);
      logic [3:0] strb;
      if (!we) begin
         strb = 4'b0000;
      end else begin
         case (size)
            2'b00:   strb = 4'b0001 << lo;
            2'b01:   strb = 4'b0011 << lo;
            2'b10:   strb = 4'b1111;
            default: strb = 4'b0000;
         endcase
      end
      return strb;
   endfunction

   function automatic logic [WIDTH-1:0] store_data(input logic [1:0] size,
                                                   input logic [WIDTH-1:0] data);
      logic [WIDTH-1:0] lanes;
      case (size)
         2'b00:   lanes = {4{data[7:0]}};
         2'b01:   lanes = {2{data[15:0]}};
         default: lanes = data;
      endcase
      return lanes;
   endfunction

   // Lane select uses the latched low address bits; the cache word is already aligned.
   function automatic logic [WIDTH-1:0] load_data(input logic [1:0] size, input logic uns,
                                                  input logic [1:0] lo,
                                                  input logic [WIDTH-1:0] rdata);
      logic [7:0]       b;
      logic [15:0]      h;
      logic [WIDTH-1:0] res;
      b = rdata[{lo, 3'b000} +: 8];
      h = rdata[{lo[1], 4'b0000} +: 16];
      case (size)
         2'b00:   res = uns ? {{(WIDTH-8){1'b0}}, b}  : {{(WIDTH-8){b[7]}}, b};
         2'b01:   res = uns ? {{(WIDTH-16){1'b0}}, h} : {{(WIDTH-16){h[15]}}, h};
         default: res = rdata;
      endcase
      return res;
   endfunction

   // Control FSM with all cache-side and response outputs held in registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r       <= ST_IDLE;
         cache_req_r   <= 1'b0;
         cache_we_r    <= 1'b0;
         cache_addr_r  <= {WIDTH{1'b0}};
         cache_wstrb_r <= 4'b0000;
         cache_wdata_r <= {WIDTH{1'b0}};
         size_r        <= 2'b00;
         unsigned_r    <= 1'b0;
         lane_r        <= 2'b00;
         resp_valid_r  <= 1'b0;
         resp_rdata_r  <= {WIDTH{1'b0}};
         resp_err_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  if (is_illegal(req_size, req_addr[1:0])) begin
                     state_r      <= ST_RESP;
                     resp_valid_r <= 1'b1;
                     resp_err_r   <= 1'b1;
                     resp_rdata_r <= {WIDTH{1'b0}};
                  end else begin
                     state_r       <= ST_ACCESS;
                     cache_req_r   <= 1'b1;
                     cache_we_r    <= req_we;
                     cache_addr_r  <= {req_addr[WIDTH-1:2], 2'b00};
                     cache_wstrb_r <= store_strb(req_we, req_size, req_addr[1:0]);
                     cache_wdata_r <= store_data(req_size, req_wdata);
                     size_r        <= req_size;
                     unsigned_r    <= req_unsigned;
                     lane_r        <= req_addr[1:0];
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               if (cache_ack) begin
                  state_r      <= ST_RESP;
                  cache_req_r  <= 1'b0;
                  resp_valid_r <= 1'b1;
                  resp_err_r   <= 1'b0;
                  resp_rdata_r <= cache_we_r ? {WIDTH{1'b0}}
                                             : load_data(size_r, unsigned_r, lane_r, cache_rdata);
               end else begin
                  state_r <= ST_ACCESS;
               end
            end
            ST_RESP: begin
               state_r      <= ST_IDLE;
               resp_valid_r <= 1'b0;
               resp_err_r   <= 1'b0;
               resp_rdata_r <= {WIDTH{1'b0}};
            end
            default: begin
               state_r      <= ST_IDLE;
               cache_req_r  <= 1'b0;
               resp_valid_r <= 1'b0;
               resp_err_r   <= 1'b0;
               resp_rdata_r <= {WIDTH{1'b0}};
            end
         endcase
      end
   end

   assign req_ready   = (state_r == ST_IDLE);
   assign stall       = ~req_ready;
   assign cache_req   = cache_req_r;
   assign cache_we    = cache_we_r;
   assign cache_addr  = cache_addr_r;
   assign cache_wstrb = cache_wstrb_r;
   assign cache_wdata = cache_wdata_r;
   assign resp_valid  = resp_valid_r;
   assign resp_rdata  = resp_rdata_r;
   assign resp_err    = resp_err_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: transaction-level reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_lsu_ctrl;

   logic        clk;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        cache_req;
   logic        cache_we;
   logic [31:0] cache_addr;
   logic [3:0]  cache_wstrb;
   logic [31:0] cache_wdata;
   logic        cache_ack;
   logic [31:0] cache_rdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        stall;

   int n_vec = 0;
   int n_fail = 0;
   int acc_cnt = 0;
   int resp_cnt = 0;

   lsu_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .cache_req(cache_req), .cache_we(cache_we), .cache_addr(cache_addr),
      .cache_wstrb(cache_wstrb), .cache_wdata(cache_wdata),
      .cache_ack(cache_ack), .cache_rdata(cache_rdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   function automatic int m_nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit m_illegal(input logic [1:0] size, input logic [31:0] addr);
      return (size == 2'd3) || ((addr % m_nbytes(size)) != 0);
   endfunction

   function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [31:0] addr);
      logic [7:0] s;
      s = ((8'd1 << m_nbytes(size)) - 8'd1) << (addr % 4);
      return s[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % m_nbytes(size)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                          input logic [31:0] addr, input logic [31:0] rd);
      logic [31:0] val;
      logic [31:0] mask;
      int nb;
      nb = m_nbytes(size);
      if (nb == 4) return rd;
      val  = rd >> (8 * (addr % 4));
      mask = (32'd1 << (8 * nb)) - 32'd1;
      val  = val & mask;
      if (!uns && val[8*nb-1]) val = val | ~mask;
      return val;
   endfunction

   bit          m_access = 1'b0;
   bit          m_resp = 1'b0;
   bit          m_err = 1'b0;
   logic [31:0] m_rdata = 32'd0;
   logic        t_we = 1'b0;
   logic [1:0]  t_size = 2'd0;
   logic        t_uns = 1'b0;
   logic [31:0] t_addr = 32'd0;
   logic [31:0] t_wdata = 32'd0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_access <= 1'b0;
         m_resp   <= 1'b0;
         m_err    <= 1'b0;
         m_rdata  <= 32'd0;
      end else if (m_resp) begin
         m_resp <= 1'b0;
      end else if (m_access) begin
         if (cache_ack) begin
            m_access <= 1'b0;
            m_resp   <= 1'b1;
            m_err    <= 1'b0;
            m_rdata  <= t_we ? 32'd0 : m_load(t_size, t_uns, t_addr, cache_rdata);
         end
      end else if (req_valid) begin
         t_we    <= req_we;
         t_size  <= req_size;
         t_uns   <= req_unsigned;
         t_addr  <= req_addr;
         t_wdata <= req_wdata;
         if (m_illegal(req_size, req_addr)) begin
            m_resp  <= 1'b1;
            m_err   <= 1'b1;
            m_rdata <= 32'd0;
         end else begin
            m_access <= 1'b1;
         end
      end
   end

   // Per-cycle compare against the model, plus acceptance/response counters.
   always @(negedge clk) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !(m_access || m_resp)});
      chk("stall", {31'd0, stall}, {31'd0, (m_access || m_resp)});
      chk("cache_req", {31'd0, cache_req}, {31'd0, m_access});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_resp});
      if (m_access) begin
         chk("cache_we", {31'd0, cache_we}, {31'd0, t_we});
         chk("cache_addr", cache_addr, t_addr & ~32'd3);
         chk("cache_wstrb", {28'd0, cache_wstrb}, {28'd0, t_we ? m_strb(t_size, t_addr) : 4'd0});
         if (t_we) chk("cache_wdata", cache_wdata, m_wdata(t_size, t_wdata));
      end
      if (m_resp) begin
         chk("resp_rdata", resp_rdata, m_rdata);
         chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
      end
      if (rstn && req_valid && req_ready) acc_cnt++;
      if (resp_valid) resp_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input string nm, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_cyc, input logic [31:0] rd,
                        input logic [3:0] exp_strb, input logic [31:0] exp_cwd,
                        input logic [31:0] exp_rdata, input logic exp_err);
      int n;
      step();
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 50) begin
         step();
         n++;
      end
      chk({nm, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      if (!exp_err) begin
         chk({nm, "_cache_req"}, {31'd0, cache_req}, 32'd1);
         chk({nm, "_cache_addr"}, cache_addr, {addr[31:2], 2'b00});
         chk({nm, "_cache_wstrb"}, {28'd0, cache_wstrb}, {28'd0, exp_strb});
         if (we) chk({nm, "_cache_wdata"}, cache_wdata, exp_cwd);
         repeat (ack_cyc - 1) step();
         chk({nm, "_held"}, {31'd0, cache_req}, 32'd1);
         cache_ack = 1'b1; cache_rdata = rd;
         step();
         cache_ack = 1'b0; cache_rdata = 32'hDEAD_BEEF;
      end else begin
         chk({nm, "_no_cache_req"}, {31'd0, cache_req}, 32'd0);
      end
      chk({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({nm, "_resp_rdata"}, resp_rdata, exp_rdata);
      chk({nm, "_resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
      step();
      chk({nm, "_resp_pulse"}, {31'd0, resp_valid}, 32'd0);
   endtask

   int r0;
   int a0;

   initial begin
      rstn = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; cache_ack = 1'b0; cache_rdata = 32'd0;
      #1 rstn = 1'b0;
      #1;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_cache_req", {31'd0, cache_req}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      step(); step();
      rstn = 1'b1;

      //     name    we    size  uns   addr          wdata         ack rdata         strb     cwdata        rdata         err
      do_op("lb",    1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0,        3, 32'h80AB_CDEF, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0);
      do_op("lhu",   1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0,        1, 32'h9234_5678, 4'b0000, 32'h0,        32'h0000_9234, 1'b0);
      do_op("lh",    1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0,        2, 32'h9234_5678, 4'b0000, 32'h0,        32'hFFFF_9234, 1'b0);
      do_op("sb",    1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_00A5, 1, 32'h1111_1111, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0);
      do_op("lw_err",1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
      do_op("sh",    1'b1, 2'd1, 1'b0, 32'h0000_5002, 32'h1234_BEEF, 2, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0);
      do_op("sw",    1'b1, 2'd2, 1'b0, 32'h0000_6000, 32'hCAFE_F00D, 1, 32'h0,        4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0);
      do_op("lw",    1'b0, 2'd2, 1'b0, 32'h0000_7004, 32'h0,        1, 32'h1357_9BDF, 4'b0000, 32'h0,        32'h1357_9BDF, 1'b0);
      do_op("lbu",   1'b0, 2'd0, 1'b1, 32'h0000_8001, 32'h0,        1, 32'h1122_F344, 4'b0000, 32'h0,        32'h0000_00F3, 1'b0);
      do_op("lb_pos",1'b0, 2'd0, 1'b0, 32'h0000_8002, 32'h0,        1, 32'h1122_F344, 4'b0000, 32'h0,        32'h0000_0022, 1'b0);
      do_op("sz_err",1'b1, 2'd3, 1'b0, 32'h0000_9000, 32'h5,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
      do_op("lh_err",1'b0, 2'd1, 1'b0, 32'h0000_9001, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
      do_op("sw_err",1'b1, 2'd2, 1'b0, 32'h0000_9003, 32'h7,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);

      // Backpressure: second request held valid through a busy period.
      step();
      a0 = acc_cnt;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h0000_0010;
      step();
      req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0000_0020; req_wdata = 32'h0BAD_F00D;
      chk("bp_ready_busy", {31'd0, req_ready}, 32'd0);
      step();
      cache_ack = 1'b1; cache_rdata = 32'h0000_00FF;
      step();
      cache_ack = 1'b0;
      chk("bp_ready_resp", {31'd0, req_ready}, 32'd0);
      chk("bp_a_rdata", resp_rdata, 32'hFFFF_FFFF);
      step();
      chk("bp_ready_idle", {31'd0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      chk("bp_b_cache_wdata", cache_wdata, 32'h0BAD_F00D);
      cache_ack = 1'b1;
      step();
      cache_ack = 1'b0;
      chk("bp_b_resp", {31'd0, resp_valid}, 32'd1);
      repeat (3) step();
      chk("bp_accept_once", acc_cnt - a0, 32'd2);

      // Reset while in ACCESS abandons the transaction.
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0040;
      step();
      req_valid = 1'b0;
      chk("rst_in_access", {31'd0, cache_req}, 32'd1);
      r0 = resp_cnt;
      #2 rstn = 1'b0;
      #1;
      chk("rst_cache_req_async", {31'd0, cache_req}, 32'd0);
      chk("rst_ready_async", {31'd0, req_ready}, 32'd1);
      cache_ack = 1'b1; cache_rdata = 32'h5555_5555;
      step();
      cache_ack = 1'b0;
      step();
      rstn = 1'b1;
      repeat (3) step();
      chk("rst_no_resp", resp_cnt - r0, 32'd0);
      do_op("post_rst", 1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h0, 1, 32'h1234_5678, 4'b0000, 32'h0, 32'h1234_5678, 1'b0);

      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data and address width in bits. Only 32 is supported.
REQ-002 clk  input  1  The block SHALL use this single clock; all state updates occur on its rising edge.
REQ-003 rstn  input  1  Reset: asynchronous assertion, active-low.
REQ-004 req_valid  input  1  Pipeline memory-op request.
REQ-005 req_ready  output  1  Block accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  Access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 req_unsigned  input  1  Load extension: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
REQ-009 req_addr  input  WIDTH  Byte address.
REQ-010 req_wdata  input  WIDTH  Store data, right-aligned.
REQ-011 cache_req  output  1  Request to the data cache.
REQ-012 cache_we  output  1  Cache write enable.
REQ-013 cache_addr  output  WIDTH  Word-aligned address: req_addr with bits [1:0] = 00.
REQ-014 cache_wstrb  output  4  Byte write strobes.
REQ-015 cache_wdata  output  WIDTH  Store data replicated into lanes.
REQ-016 cache_ack  input  1  Cache completion; cache_rdata is valid in the same cycle.
REQ-017 cache_rdata  input  WIDTH  Cache read word.
REQ-018 resp_valid  output  1  One-cycle completion pulse.
REQ-019 resp_rdata  output  WIDTH  Extended load result; 0 for stores and errors.
REQ-020 resp_err  output  1  Address or size error, valid with resp_valid.
REQ-021 stall  output  1  Pipeline hold; equals the inverse of req_ready.

Function
REQ-022 The block SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-023 The block SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a clock edge.
REQ-024 When an accepted request is legal, the block SHALL transition IDLE->ACCESS and latch all req_* fields.
REQ-025 When an accepted request is illegal, the block SHALL transition IDLE->RESP with the error flag set and SHALL issue no cache request.
REQ-026 A request SHALL be illegal when req_size = 11, when it is a half access with addr[0] = 1, or when it is a word access with addr[1:0] != 00.
REQ-027 In ACCESS, the block SHALL hold cache_req = 1 and hold cache_we, cache_addr, cache_wstrb and cache_wdata stable until cache_ack = 1.
REQ-028 When cache_ack = 1 in ACCESS, the block SHALL transition ACCESS->RESP and register the load result in the same edge.
REQ-029 The block SHALL drive cache_req = 0 in every state other than ACCESS, and SHALL ignore cache_ack outside ACCESS.
REQ-030 In RESP, the block SHALL drive resp_valid = 1 for exactly one cycle, then transition RESP->IDLE.
REQ-031 Minimum latency SHALL be: accept edge, then ACCESS for 1 or more cycles, then RESP; resp_valid first rises 2 cycles after acceptance when cache_ack arrives in the first ACCESS cycle.
REQ-032 Byte store strobes SHALL be 0001 << addr[1:0], with cache_wdata = {4{wdata[7:0]}}.
REQ-033 Half store strobes SHALL be 0011 << addr[1:0], with cache_wdata = {2{wdata[15:0]}}.
REQ-034 Word store strobes SHALL be 1111, with cache_wdata = wdata.
REQ-035 For loads, cache_wstrb SHALL be 0000.
REQ-036 A byte load SHALL select the lane cache_rdata[8*addr[1:0] +: 8].
REQ-037 A half load SHALL select the lane cache_rdata[16*addr[1] +: 16].
REQ-038 A load result SHALL be the selected lane sign-extended from its top bit when unsigned = 0, and zero-extended to WIDTH when unsigned = 1.
REQ-039 Word loads SHALL pass cache_rdata through unmodified.
REQ-040 For stores and error responses, the block SHALL drive resp_rdata = 0.
REQ-041 A req_valid raised while the block is busy SHALL be neither accepted nor lost; the pipeline holds it under stall.

Reset
REQ-042 While rstn = 0, the block SHALL immediately force state = IDLE, cache_req = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, latched fields = 0, and req_ready = 1 once released.
REQ-043 Reset asserted during ACCESS SHALL abandon the transaction, and the block SHALL produce no response for it.

Verification
REQ-044 Byte load test: LB addr 0x1003, ack after 3 cycles, rdata 0x80AB_CDEF -> cache_addr 0x1000, resp_rdata 0xFFFF_FF80, resp_valid exactly 1 cycle.
REQ-045 Half load test: LHU addr 0x2002, rdata 0x9234_5678 -> resp_rdata 0x0000_9234; LH at the same address -> 0xFFFF_9234.
REQ-046 Byte store test: SB addr 0x3001, wdata 0x0000_00A5 -> cache_wstrb 0010, cache_wdata 0xA5A5_A5A5, resp_rdata 0.
REQ-047 Error test: LW addr 0x4002 -> no cache_req pulse, resp_valid with resp_err = 1 one cycle after acceptance.
REQ-048 Reset test: assert rstn low while in ACCESS -> cache_req falls without a clock edge, no resp_valid follows, and the next request completes normally.
REQ-049 Backpressure test: req_valid held through a busy period -> req_ready = 0 until RESP->IDLE, then the request is accepted exactly once.
